// File: rtl/hazard_scoreboard.sv
// Purpose: load-use stall, redirect flush and operand-forwarding select generation for the in-order pipeline.
// Latency: stall/flush_fd are combinational in the decode cycle; e_fwd_rs1/e_fwd_rs2 are registered and apply in execute one cycle later.
// Backpressure: stall holds PC and F/D and injects an execute bubble; redirect overrides stall and squashes F/D.
// Optional feature: define HAZARD_PERF_EN to add the perf_stalls / perf_flushes cycle counters.
module hazard_scoreboard #(
    parameter int PIPE_DEPTH    = 3,
    parameter int REG_AW        = 5,
    parameter int LOAD_FWD_SLOT = 2,
    parameter int FWD_W         = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs1,
    input  logic [REG_AW-1:0] d_rs2,
    input  logic              d_uses_rs1,
    input  logic              d_uses_rs2,
    input  logic [REG_AW-1:0] d_rd,
    input  logic              d_we,
    input  logic              d_is_load,
    input  logic              redirect,
    output logic              stall,
    output logic              flush_fd,
    output logic [FWD_W-1:0]  e_fwd_rs1,
    output logic [FWD_W-1:0]  e_fwd_rs2
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_stalls,
    output logic [31:0]       perf_flushes
`endif
);

    // One in-flight producer: slot 0 is execute, slot PIPE_DEPTH-1 is writeback.
    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic              ld;
    } sb_entry_t;

    sb_entry_t        sb [PIPE_DEPTH];
    logic [FWD_W-1:0] sel_rs1;
    logic [FWD_W-1:0] sel_rs2;
    logic             lu_rs1;
    logic             lu_rs2;
    logic             accept;

    // Youngest matching producer per operand; scan oldest-to-youngest so the lowest slot wins.
    always_comb begin
        sel_rs1 = '0;
        sel_rs2 = '0;
        lu_rs1  = 1'b0;
        lu_rs2  = 1'b0;
        for (int j = PIPE_DEPTH - 1; j >= 0; j--) begin
            if (sb[j].vld && (sb[j].rd == d_rs1)) begin
                sel_rs1 = FWD_W'(j + 1);
                lu_rs1  = sb[j].ld && ((j + 1) < LOAD_FWD_SLOT);
            end
            if (sb[j].vld && (sb[j].rd == d_rs2)) begin
                sel_rs2 = FWD_W'(j + 1);
                lu_rs2  = sb[j].ld && ((j + 1) < LOAD_FWD_SLOT);
            end
        end
        // x0, unused operands and empty decode slots never create a dependency.
        if (!(d_valid && d_uses_rs1 && (d_rs1 != '0))) begin
            sel_rs1 = '0;
            lu_rs1  = 1'b0;
        end
        if (!(d_valid && d_uses_rs2 && (d_rs2 != '0))) begin
            sel_rs2 = '0;
            lu_rs2  = 1'b0;
        end
    end

    // A taken redirect squashes decode, so any load-use stall it would have caused is moot.
    always_comb begin
        flush_fd = redirect;
        stall    = (lu_rs1 || lu_rs2) && !redirect;
        accept   = d_valid && !stall && !redirect;
    end

    // Shift the scoreboard one stage per cycle; slot 0 gets the issuing instruction or a bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                sb[k] <= '0;
            end
        end else begin
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                sb[k] <= sb[k-1];
            end
            sb[0].vld <= accept && d_we && (d_rd != '0);
            sb[0].rd  <= d_rd;
            sb[0].ld  <= d_is_load;
        end
    end

    // Selects follow the instruction into execute; stalled, flushed or empty issue forwards nothing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            e_fwd_rs1 <= '0;
            e_fwd_rs2 <= '0;
        end else begin
            e_fwd_rs1 <= accept ? sel_rs1 : '0;
            e_fwd_rs2 <= accept ? sel_rs2 : '0;
        end
    end

`ifdef HAZARD_PERF_EN
    // Free-running event counters; they wrap naturally at 2^32.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_stalls  <= '0;
            perf_flushes <= '0;
        end else begin
            if (stall)    perf_stalls  <= perf_stalls + 32'd1;
            if (flush_fd) perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Purpose: directed, table-driven checks of hazard_scoreboard stall, flush and forwarding selects.
// Latency: each table row is one clock; its expected selects reflect the previous row's decode.
// Backpressure: stalled rows are repeated by the table itself, as the fetch stage would.
module tb_hazard_scoreboard;

    logic       clock;
    logic       reset;
    logic       d_valid;
    logic [4:0] d_rs1;
    logic [4:0] d_rs2;
    logic       d_uses_rs1;
    logic       d_uses_rs2;
    logic [4:0] d_rd;
    logic       d_we;
    logic       d_is_load;
    logic       redirect;
    logic       stall;
    logic       flush_fd;
    logic [1:0] e_fwd_rs1;
    logic [1:0] e_fwd_rs2;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stalls;
    logic [31:0] perf_flushes;
`endif

    int errors = 0;
    int checks = 0;

    hazard_scoreboard dut (
        .clock      (clock),
        .reset      (reset),
        .d_valid    (d_valid),
        .d_rs1      (d_rs1),
        .d_rs2      (d_rs2),
        .d_uses_rs1 (d_uses_rs1),
        .d_uses_rs2 (d_uses_rs2),
        .d_rd       (d_rd),
        .d_we       (d_we),
        .d_is_load  (d_is_load),
        .redirect   (redirect),
        .stall      (stall),
        .flush_fd   (flush_fd),
        .e_fwd_rs1  (e_fwd_rs1),
        .e_fwd_rs2  (e_fwd_rs2)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stalls  (perf_stalls),
        .perf_flushes (perf_flushes)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       redir;
        logic       ex_stall;
        logic       ex_flush;
        logic [1:0] ex_f1;
        logic [1:0] ex_f2;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int rs1, input int rs2, input logic u1, input logic u2,
                         input int rd, input logic we, input logic ld, input logic redir);
        d_valid    = v;
        d_rs1      = 5'(rs1);
        d_rs2      = 5'(rs2);
        d_uses_rs1 = u1;
        d_uses_rs2 = u2;
        d_rd       = 5'(rd);
        d_we       = we;
        d_is_load  = ld;
        redirect   = redir;
    endtask

    task automatic vec(input logic v, input int rs1, input int rs2, input logic u1, input logic u2,
                       input int rd, input logic we, input logic ld, input logic redir,
                       input logic es, input logic ef, input int f1, input int f2);
        vec_t x;
        x.v = v; x.rs1 = 5'(rs1); x.rs2 = 5'(rs2); x.u1 = u1; x.u2 = u2;
        x.rd = 5'(rd); x.we = we; x.ld = ld; x.redir = redir;
        x.ex_stall = es; x.ex_flush = ef; x.ex_f1 = 2'(f1); x.ex_f2 = 2'(f2);
        vecs.push_back(x);
    endtask

    task automatic idle(input int f1, input int f2);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, f1, f2);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ALU chain: forwarding from slots 0, 1 and the retired-writeback holder (3).
        vec(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0);   // ADD x5,x1,x2
        vec(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0);   // ADD x6,x5,x1
        vec(1, 5, 6, 1, 1, 8, 1, 0, 0, 0, 0, 1, 0);   // ADD x8,x5,x6
        vec(1, 5, 0, 1, 1, 9, 1, 0, 0, 0, 0, 2, 1);   // ADD x9,x5,x0
        idle(3, 0); idle(0, 0); idle(0, 0);
        // Load-use: one bubble, then forward from writeback on both operands.
        vec(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0);   // LW x5
        vec(1, 5, 5, 1, 1, 7, 1, 0, 0, 1, 0, 0, 0);   // ADD x7,x5,x5 stalls
        vec(1, 5, 5, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0);   // ADD retried
        idle(2, 2); idle(0, 0); idle(0, 0);
        // x0 destination never creates an entry.
        vec(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);   // LW x0
        vec(1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);   // ADD x1,x0,x0
        idle(0, 0); idle(0, 0); idle(0, 0);
        // Youngest producer wins: the load in slot 0 shadows the older ADD.
        vec(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0);   // ADD x3
        vec(1, 1, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0);   // LW x3
        vec(1, 3, 0, 1, 1, 4, 1, 0, 0, 1, 0, 0, 0);   // ADD x4,x3,x0 stalls
        vec(1, 3, 0, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0);
        idle(2, 0); idle(0, 0); idle(0, 0);
        // Redirect during a load-use: flush, no stall, slot 0 left empty.
        vec(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0);   // LW x5
        vec(1, 5, 5, 1, 1, 7, 1, 0, 1, 0, 1, 0, 0);   // ADD x7 + redirect
        vec(1, 7, 5, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0);   // ADD x8,x7,x5
        idle(0, 2); idle(0, 0); idle(0, 0);
        // Unused operands and empty decode do not stall; stores do.
        vec(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0);   // LW x5
        vec(1, 5, 5, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0);   // LUI x9 (fields alias x5)
        vec(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0);   // LW x5
        vec(0, 5, 5, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0);   // not a real instruction
        vec(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0);   // LW x5
        vec(1, 6, 5, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);   // SW x5,0(x6) stalls
        vec(1, 6, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 2); idle(0, 0); idle(0, 0);

        // Reset state, before and after a clock edge under reset.
        #2;
        check("rst_stall", 32'(stall), 0);
        check("rst_flush", 32'(flush_fd), 0);
        check("rst_fwd1", 32'(e_fwd_rs1), 0);
        check("rst_fwd2", 32'(e_fwd_rs2), 0);
        next_cycle();
        reset = 1'b0;
        check("rst_fwd1_edge", 32'(e_fwd_rs1), 0);

        foreach (vecs[i]) begin
            drive(vecs[i].v, int'(vecs[i].rs1), int'(vecs[i].rs2), vecs[i].u1, vecs[i].u2,
                  int'(vecs[i].rd), vecs[i].we, vecs[i].ld, vecs[i].redir);
            #3;
            check($sformatf("row%0d_stall", i), 32'(stall), 32'(vecs[i].ex_stall));
            check($sformatf("row%0d_flush", i), 32'(flush_fd), 32'(vecs[i].ex_flush));
            check($sformatf("row%0d_fwd1", i), 32'(e_fwd_rs1), 32'(vecs[i].ex_f1));
            check($sformatf("row%0d_fwd2", i), 32'(e_fwd_rs2), 32'(vecs[i].ex_f2));
            next_cycle();
        end

        // Asynchronous reset while a load-use stall is active.
        drive(1, 1, 2, 1, 1, 5, 1, 0, 0);             // ADD x5
        next_cycle();
        drive(1, 5, 0, 1, 0, 6, 1, 1, 0);             // LW x6,0(x5)
        next_cycle();
        drive(1, 6, 6, 1, 1, 7, 1, 0, 0);             // ADD x7,x6,x6
        #2;
        check("mid_pre_stall", 32'(stall), 1);
        check("mid_pre_fwd1", 32'(e_fwd_rs1), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_stall", 32'(stall), 0);
        check("mid_rst_flush", 32'(flush_fd), 0);
        check("mid_rst_fwd1", 32'(e_fwd_rs1), 0);
        check("mid_rst_fwd2", 32'(e_fwd_rs2), 0);
`ifdef HAZARD_PERF_EN
        check("mid_rst_perf_stalls", perf_stalls, 0);
        check("mid_rst_perf_flushes", perf_flushes, 0);
`endif
        next_cycle();
        reset = 1'b0;
        #2;
        check("post_rst_stall", 32'(stall), 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) next_cycle();

        // Three back-to-back load-use pairs.
        for (int p = 0; p < 3; p++) begin
            drive(1, 1, 0, 1, 0, 5, 1, 1, 0);         // LW x5
            #3;
            check($sformatf("pair%0d_lw_stall", p), 32'(stall), 0);
            next_cycle();
            drive(1, 5, 5, 1, 1, 7, 1, 0, 0);         // ADD x7,x5,x5
            #3;
            check($sformatf("pair%0d_use_stall", p), 32'(stall), 1);
            next_cycle();
            #3;
            check($sformatf("pair%0d_retry_stall", p), 32'(stall), 0);
            next_cycle();
            #3;
            check($sformatf("pair%0d_fwd1", p), 32'(e_fwd_rs1), 2);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) next_cycle();
`ifdef HAZARD_PERF_EN
        check("perf_stalls_3", perf_stalls, 3);
        check("perf_flushes_0", perf_flushes, 0);
`endif
        for (int c = 0; c < 2; c++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
            #3;
            check($sformatf("redir%0d_flush", c), 32'(flush_fd), 1);
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        check("redir_done_flush", 32'(flush_fd), 0);
`ifdef HAZARD_PERF_EN
        check("perf_flushes_2", perf_flushes, 2);
        check("perf_stalls_hold", perf_stalls, 3);
`endif
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the in-order RISC-V pipeline.
- Generalises the fixed load-use stall and bypass decisions to a configurable number of post-decode stages and a configurable load-data-ready stage.
- Tracks every in-flight destination register in a shift-register scoreboard.
- Generates decode stall, fetch/decode flush, and registered per-operand forwarding selects consumed by execute one cycle later.

Parameters:
- PIPE_DEPTH, 3: post-decode stages tracked; slot 0 = execute, slot PIPE_DEPTH-1 = writeback.
- REG_AW, 5: register address width.
- LOAD_FWD_SLOT, 2: first slot, at the time the consumer is in execute, where load data is forwardable. 2 = writeback.
- FWD_W, 2: width of forwarding selects; must satisfy 2^FWD_W > PIPE_DEPTH.

Ports:
- clock  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- d_valid  in  1  decode holds a real instruction
- d_rs1  in  REG_AW  decode rs1 address
- d_rs2  in  REG_AW  decode rs2 address
- d_uses_rs1  in  1  instruction reads rs1
- d_uses_rs2  in  1  instruction reads rs2 (includes stores and branches)
- d_rd  in  REG_AW  decode destination address
- d_we  in  1  instruction writes rd
- d_is_load  in  1  instruction is a load
- redirect  in  1  execute resolved a taken branch or jump this cycle
- stall  out  1  hold PC and the F/D register; insert bubble into execute
- flush_fd  out  1  squash the fetch and decode instructions
- e_fwd_rs1  out  FWD_W  execute rs1 source. 0 = register-file value; k = result of producer now in slot k (k = PIPE_DEPTH selects the datapath's retired-writeback holding register)
- e_fwd_rs2  out  FWD_W  same, for rs2

Behaviour:
- Scoreboard entry per slot: {valid, rd, is_load}. Entries are only created when d_we=1 and d_rd!=0.
- Reset (asynchronous): all entries invalid; e_fwd_rs1=0, e_fwd_rs2=0.
- stall and flush_fd are combinational from the current state and inputs.
- Match for operand rsX: the youngest (lowest index) slot j with valid and rd==d_rsX, qualified by d_valid, d_uses_rsX and d_rsX!=0.
- Load-use stall:
  - Condition: a matching entry has is_load and j+1 < LOAD_FWD_SLOT.
  - stall is the OR over both operands.
  - Stores and branches are not exempt.
- Redirect:
  - flush_fd = redirect.
  - redirect forces stall=0; redirect takes priority over stall.
- Each clock edge:
  - Slots k = 1..PIPE_DEPTH-1 take slot k-1.
  - Slot 0 takes the decode entry when d_valid and !stall and !redirect; otherwise slot 0 becomes invalid (bubble).
  - The oldest entry retires.
- Forwarding selects, registered on the same edge:
  - If a match exists at slot j with j+1 <= PIPE_DEPTH, e_fwd_rsX <= j+1; otherwise e_fwd_rsX <= 0.
  - A stall, redirect or invalid decode loads 0.
- Latency: a hazard is visible on stall in the same cycle; selects apply one cycle later.
- Multi-cycle stalls are permitted: stall stays asserted while the load-use condition holds, and re-evaluates each cycle as the load advances.
- Simultaneous redirect and load-use: flush wins; no stall.
- Reset mid-stall: all outputs drop immediately.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, two additional outputs are present:
  - perf_stalls (32 bits): increments every cycle with stall=1.
  - perf_flushes (32 bits): increments every cycle with flush_fd=1.
- Both counters clear on reset and wrap at 2^32.
- When not defined, the ports and counters are absent and there is no other behavioural difference.

Test Plan:
- ALU back-to-back: ADD x5 then ADD x6,x5,x1, with default parameters. Expect stall=0; next cycle e_fwd_rs1=1.
- Load-use: LW x5 then ADD x7,x5,x5. Expect stall=1 for exactly one cycle; after the bubble, e_fwd_rs1=2 and e_fwd_rs2=2.
- x0 destination: LW x0 then ADD x1,x0,x0. Expect stall=0 and selects 0.
- Youngest wins: ADD x3 in slot 1 and LW x3 in slot 0, then decode uses x3. Expect stall=1; after the bubble, e_fwd_rs1 selects the load (2), not the older ADD.
- Redirect during load-use: redirect=1 in the same cycle as the stall condition. Expect flush_fd=1 and stall=0; slot 0 is invalid next cycle.
- Reset mid-stall, with HAZARD_PERF_EN defined: assert reset asynchronously while stall=1. Expect stall=0, selects 0 and perf counters 0 before the next edge; perf_stalls counts 3 after three load-use pairs.
